// File: rtl/msx2_mapper_pkg.sv
// msx2_mapper_pkg: shared types and constants for the MSX2 memory mapper
package msx2_mapper_pkg;
    localparam int SEG_BITS_DEF = 8;
    localparam logic [7:0] MAPPER_PORT_BASE = 8'hFC;
    localparam logic [7:0] PAGE_RESET = {2'd3, 2'd2, 2'd1, 2'd0};
    typedef logic [SEG_BITS_DEF-1:0] seg_t;
    typedef enum logic {IDLE, WAIT_ACK} state_t;
endpackage

// File: rtl/msx2_mapper_regs.sv
// msx2_mapper_regs: page registers, port decode, address translation; readback under MSX2_MAPPER_READBACK_EN
module msx2_mapper_regs
    import msx2_mapper_pkg::*;
#(
    parameter int SEG_BITS = 8,
    parameter logic [7:0] SEG_MASK = 8'hFF,
    parameter logic [7:0] IO_BASE = MAPPER_PORT_BASE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                io_wr,
    input  logic                io_rd,
    input  logic [7:0]          io_addr,
    input  logic [7:0]          cpu_din,
    input  logic [1:0]          page,
    output logic [SEG_BITS-1:0] seg,
    output logic                output_rq,
    output logic [7:0]          data
);
    logic [SEG_BITS-1:0] p [4];
    logic sel;
    assign sel = io_addr[7:2] == IO_BASE[7:2];
    assign seg = p[page];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            for (int i = 0; i < 4; i++) p[i] <= SEG_BITS'(PAGE_RESET[6-2*i +: 2]);
        else if (io_wr && sel)
            p[io_addr[1:0]] <= cpu_din[SEG_BITS-1:0] & SEG_MASK[SEG_BITS-1:0];
`ifdef MSX2_MAPPER_READBACK_EN
    assign output_rq = io_rd && sel;
    assign data = output_rq ? (~SEG_MASK | 8'(p[io_addr[1:0]])) : 8'hFF;
`else
    logic unused_rd;
    assign unused_rd = io_rd;
    assign output_rq = 1'b0;
    assign data = 8'hFF;
`endif
endmodule

// File: rtl/msx2_ram_mapper_ctrl.sv
// msx2_ram_mapper_ctrl: MSX2 mapper plus RAM access sequencer; readback under MSX2_MAPPER_READBACK_EN
module msx2_ram_mapper_ctrl
    import msx2_mapper_pkg::*;
#(
    parameter int SEG_BITS = 8,
    parameter logic [7:0] SEG_MASK = 8'hFF,
    parameter logic [7:0] IO_BASE = MAPPER_PORT_BASE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   io_wr,
    input  logic                   io_rd,
    input  logic [7:0]             io_addr,
    input  logic [7:0]             cpu_din,
    input  logic                   mem_req,
    input  logic                   mem_wr,
    input  logic [15:0]            mem_addr,
    output logic                   cpu_wait,
    output logic                   ram_req,
    output logic                   ram_we,
    output logic [14+SEG_BITS-1:0] ram_addr,
    output logic [7:0]             ram_din,
    input  logic                   ram_ack,
    output logic                   output_rq,
    output logic [7:0]             data
);
    state_t state, state_nxt;
    logic [SEG_BITS-1:0] seg;
    logic start;
    msx2_mapper_regs #(.SEG_BITS(SEG_BITS), .SEG_MASK(SEG_MASK), .IO_BASE(IO_BASE)) u_regs (
        .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
        .cpu_din(cpu_din), .page(mem_addr[15:14]), .seg(seg), .output_rq(output_rq), .data(data)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = (state == IDLE) ? (mem_req ? WAIT_ACK : IDLE) : (ram_ack ? IDLE : WAIT_ACK);
        start = state == IDLE && mem_req;
        cpu_wait = state == WAIT_ACK;
        ram_req = state == WAIT_ACK;
    end
    // seg is sampled before any coincident page write lands, so the access sees the old page value
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ram_addr <= '0;
            ram_we <= 1'b0;
            ram_din <= 8'h00;
        end else if (start) begin
            ram_addr <= {seg, mem_addr[13:0]};
            ram_we <= mem_wr;
            ram_din <= cpu_din;
        end
endmodule

// File: tb/tb_msx2_ram_mapper_ctrl.sv
// tb_msx2_ram_mapper_ctrl: directed bench with transaction scoreboard for msx2_ram_mapper_ctrl
module tb_msx2_ram_mapper_ctrl;
    logic clk = 0, reset_n = 0, io_wr = 0, io_rd = 0, mem_req = 0, mem_wr = 0, ram_ack = 0;
    logic [7:0] io_addr = 0, cpu_din = 0;
    logic [15:0] mem_addr = 0;
    logic cpu_wait, ram_req, ram_we, output_rq;
    logic [21:0] ram_addr;
    logic [7:0] ram_din, data;
    int n_cmp = 0, n_err = 0, n_push = 0, n_pop = 0;
    typedef struct packed {logic [21:0] a; logic we; logic [7:0] d;} txn_t;
    txn_t q[$];
    txn_t cur;
    logic prev_req = 0;

    always #5 clk = ~clk;

    msx2_ram_mapper_ctrl #(.SEG_BITS(8), .SEG_MASK(8'h3F), .IO_BASE(8'hFC)) dut (
        .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr),
        .cpu_din(cpu_din), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .cpu_wait(cpu_wait), .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_ack(ram_ack), .output_rq(output_rq), .data(data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // each new RAM request pops one expectation; later cycles of it must hold steady
    always @(negedge clk) begin
        if (reset_n && ram_req) begin
            if (!prev_req) begin
                chk("txn_pending", q.size(), 1);
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    n_pop++;
                    chk("txn_addr", ram_addr, cur.a);
                    chk("txn_we", ram_we, cur.we);
                    chk("txn_din", ram_din, cur.d);
                end
            end else begin
                chk("hold_addr", ram_addr, cur.a);
                chk("hold_we", ram_we, cur.we);
                chk("hold_din", ram_din, cur.d);
            end
        end
        prev_req = reset_n && ram_req;
    end

    task automatic mapper_wr(input logic [7:0] port, input logic [7:0] d);
        io_wr = 1; io_addr = port; cpu_din = d;
        step;
        io_wr = 0;
    endtask

    // sw: 0 none, 1 page write with mem_req, 2 page write during wait, 3 extra mem_req during wait
    task automatic access(input logic [15:0] a, input logic wr, input logic [7:0] d, input int n,
                          input logic [21:0] exp, input int sw, input logic [7:0] sp, input logic [7:0] sd);
        int waits = 0;
        q.push_back(txn_t'{a: exp, we: wr, d: d});
        n_push++;
        mem_req = 1; mem_wr = wr; mem_addr = a; cpu_din = d;
        if (sw == 1) begin io_wr = 1; io_addr = sp; end
        step;
        mem_req = 0; mem_wr = 0; io_wr = 0;
        while (cpu_wait && waits < 40) begin
            waits++;
            if (sw == 2 && waits == 1) begin io_wr = 1; io_addr = sp; cpu_din = sd; end
            else io_wr = 0;
            if (sw == 3 && waits == 1) begin mem_req = 1; mem_wr = 1; mem_addr = 16'h0000; end
            else mem_req = 0;
            ram_ack = (waits == n);
            step;
        end
        ram_ack = 0; io_wr = 0; mem_req = 0; mem_wr = 0;
        chk("wait_cycles", waits, n);
        chk("req_after_ack", ram_req, 0);
    endtask

    initial begin
        #12;
        chk("rst_cpu_wait", cpu_wait, 0);
        chk("rst_ram_req", ram_req, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_output_rq", output_rq, 0);
        chk("rst_data", data, 8'hFF);
        step;
        reset_n = 1;
        step;
        access(16'h4000, 0, 8'h00, 4, 22'h08000, 0, 0, 0);
        mapper_wr(8'hFE, 8'h05);
        access(16'h8123, 1, 8'hA5, 3, 22'h14123, 0, 0, 0);
        access(16'hC000, 0, 8'h11, 3, 22'h00000, 2, 8'hFF, 8'h07);
        access(16'hC000, 0, 8'h22, 1, 22'h1C000, 0, 0, 0);
        access(16'h4000, 0, 8'h09, 1, 22'h08000, 1, 8'hFD, 0);
        access(16'h4000, 0, 8'h33, 2, 22'h24000, 0, 0, 0);
        ram_ack = 1;
        step;
        ram_ack = 0;
        chk("idle_ack_wait", cpu_wait, 0);
        chk("idle_ack_req", ram_req, 0);
        access(16'h0123, 1, 8'h44, 3, 22'h0C123, 3, 0, 0);
        step;
        step;
        chk("single_txn", n_pop, n_push);
        mapper_wr(8'hFC, 8'hFF);
        access(16'h0000, 0, 8'h55, 1, 22'hFC000, 0, 0, 0);
        io_rd = 1; io_addr = 8'hFC;
        #1;
`ifdef MSX2_MAPPER_READBACK_EN
        chk("rb_rq_ff", output_rq, 1);
        chk("rb_data_ff", data, 8'hFF);
`else
        chk("rb_rq_off", output_rq, 0);
        chk("rb_data_off", data, 8'hFF);
`endif
        io_rd = 0;
        mapper_wr(8'hFC, 8'h01);
        io_rd = 1; io_addr = 8'hFC;
        #1;
`ifdef MSX2_MAPPER_READBACK_EN
        chk("rb_rq_01", output_rq, 1);
        chk("rb_data_01", data, 8'hC1);
`else
        chk("rb_rq_off2", output_rq, 0);
        chk("rb_data_off2", data, 8'hFF);
`endif
        io_addr = 8'hFB;
        #1;
        chk("rb_nosel_rq", output_rq, 0);
        chk("rb_nosel_data", data, 8'hFF);
        io_rd = 0;
        step;
        access(16'h0000, 0, 8'h66, 1, 22'h04000, 0, 0, 0);
        q.push_back(txn_t'{a: 22'h1C000, we: 1'b1, d: 8'h77});
        n_push++;
        mem_req = 1; mem_wr = 1; mem_addr = 16'hC000; cpu_din = 8'h77;
        step;
        mem_req = 0; mem_wr = 0;
        chk("mid_wait_hi", cpu_wait, 1);
        @(negedge clk);
        #1 reset_n = 0;
        #1;
        chk("async_rst_req", ram_req, 0);
        chk("async_rst_wait", cpu_wait, 0);
        chk("async_rst_addr", ram_addr, 0);
        step;
        reset_n = 1;
        step;
        access(16'h0000, 0, 8'h01, 1, 22'h0C000, 0, 0, 0);
        access(16'h4000, 0, 8'h02, 1, 22'h08000, 0, 0, 0);
        access(16'h8000, 0, 8'h03, 1, 22'h04000, 0, 0, 0);
        access(16'hC000, 0, 8'h04, 1, 22'h00000, 0, 0, 0);
        step;
        chk("txn_count", n_pop, n_push);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule

// File: doc/msx2_ram_mapper_ctrl.md
Name: msx2_ram_mapper_ctrl

Overview:
- Controller for the MSX2 main RAM: implements the memory mapper page registers (I/O ports 0xFC–0xFF) and sequences CPU memory accesses onto the single-port RAM request/acknowledge interface.
- Translates the 16-bit Z80 address into a segment-based RAM address and holds the CPU in wait until the RAM acknowledges.
- Sits between the CPU bus decode and the SDRAM/BRAM RAM port.
- Supplies mapper readback data for the I/O read mux.

Parameters:
- SEG_BITS, 8, width of each segment register (256 × 16 KB = 4 MB max).
- SEG_MASK, 8'hFF, implemented-segment mask; unimplemented register bits read back as 1.
- IO_BASE, 8'hFC, first mapper port; occupies IO_BASE..IO_BASE+3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- io_wr  in  1  one-cycle I/O write strobe
- io_rd  in  1  I/O read qualifier
- io_addr  in  8  I/O port address
- cpu_din  in  8  CPU write data
- mem_req  in  1  one-cycle memory access start pulse (RAM slot selected)
- mem_wr  in  1  1 = write, sampled with mem_req
- mem_addr  in  16  CPU address, sampled with mem_req
- cpu_wait  out  1  wait request to CPU
- ram_req  out  1  RAM request, held until ack
- ram_we  out  1  RAM write enable
- ram_addr  out  14+SEG_BITS  RAM byte address
- ram_din  out  8  RAM write data
- ram_ack  in  1  one-cycle RAM completion
- output_rq  out  1  mapper readback valid
- data  out  8  mapper readback data (8'hFF when not selected)

Behaviour:
- Reset (async, reset_n=0):
  - page registers P0..P3 = 3, 2, 1, 0
  - FSM = IDLE
  - cpu_wait = ram_req = ram_we = output_rq = 0
  - ram_addr = ram_din = 0
  - data = 8'hFF
- Mapper write:
  - io_wr && io_addr[7:2]==IO_BASE[7:2] → P[io_addr[1:0]] <= cpu_din[SEG_BITS-1:0] & SEG_MASK, next edge.
  - Accepted in every FSM state.
- Address map: page = mem_addr[15:14]; ram_addr = {P[page], mem_addr[13:0]}.
- FSM:
  - IDLE: on mem_req → latch ram_addr (from the current P), ram_we = mem_wr, ram_din = cpu_din; assert ram_req and cpu_wait in the same edge; go to WAIT_ACK.
  - WAIT_ACK: hold ram_req, ram_addr, ram_we, ram_din stable. On ram_ack → drop ram_req and cpu_wait next edge; go to IDLE.
- Latency:
  - cpu_wait rises the cycle after mem_req and falls the cycle after ram_ack.
  - Minimum access = 2 cycles (ack in the first WAIT_ACK cycle).
- mem_req while in WAIT_ACK: ignored; no queueing. The CPU cannot issue one while waited.
- ram_ack in IDLE: ignored.
- Mapper write during WAIT_ACK: updates P but does not alter the latched in-flight ram_addr.
- Mapper write coinciding with mem_req to the same page: the access uses the old P value (registered read before update).
- reset_n asserted mid-access: FSM → IDLE, ram_req and cpu_wait drop immediately. The RAM side must tolerate an abandoned request.
- Readback is combinational from P, see Optional Feature.

Optional Feature:
- Macro: MSX2_MAPPER_READBACK_EN.
- Defined:
  - io_rd && port match → output_rq = 1, data = {~SEG_MASK | P[io_addr[1:0]]} (unimplemented bits read 1).
  - Otherwise output_rq = 0, data = 8'hFF.
- Undefined (write-only mapper, as on some MSX2 machines): output_rq tied 0, data tied 8'hFF. Readback logic absent.

Decomposition:
- Shared package msx2_mapper_pkg:
  - typedef seg_t (logic [SEG_BITS-1:0])
  - FSM enum state_t {IDLE, WAIT_ACK}
  - localparam MAPPER_PORT_BASE = 8'hFC
  - localparam PAGE_RESET = {3, 2, 1, 0}
- One natural sub-module: msx2_mapper_regs, holding the page register file, write decode, readback and combinational address translation. The FSM stays in the top.

Test Plan:
- Reset then mem_req rd at 0x4000, ack after 3 cycles → ram_addr = 0x08000 (P1=2), cpu_wait high for exactly 4 cycles, ram_we = 0.
- io_wr port 0xFE data 0x05, then mem_req wr 0x8123 data 0xA5 → ram_addr = 0x14123, ram_we = 1, ram_din = 0xA5, held stable until ack.
- SEG_MASK = 8'h3F, write 0xFF to port 0xFC, io_rd 0xFC → output_rq = 1, data = 0xFF. Write 0x01 → data = 0xC1. Feature off → output_rq = 0, data = 0xFF.
- During WAIT_ACK, io_wr 0xFF = 0x07 → in-flight ram_addr unchanged; next access at 0xC000 → ram_addr = 0x1C000.
- Spurious ram_ack in IDLE and a second mem_req during WAIT_ACK → no state change, single RAM transaction.
- reset_n low mid-WAIT_ACK → ram_req and cpu_wait = 0 asynchronously, P back to 3, 2, 1, 0.
